// File: rtl/dac_gain_scaler_pkg.sv
// Shared constants and helpers for the DAC gain scaler: clip counter width,
// ramp direction encoding and the saturation / midscale constant functions.
package dac_gain_scaler_pkg;

   localparam int CLIP_CNT_W = 16;

   typedef enum logic [1:0] {
      RAMP_HOLD = 2'd0,
      RAMP_UP   = 2'd1,
      RAMP_DOWN = 2'd2
   } ramp_dir_e;

   // Largest positive value of a w-bit two's complement number
   function automatic longint signed_max(input int w);
      return (longint'(1) <<< (w - 1)) - longint'(1);
   endfunction

   // Most negative value of a w-bit two's complement number
   function automatic longint signed_min(input int w);
      return -(longint'(1) <<< (w - 1));
   endfunction

   // DAC code that represents zero amplitude in the selected output format
   function automatic longint midscale_code(input int out_w, input int offset_bin);
      return (offset_bin != 0) ? (longint'(1) << (out_w - 1)) : longint'(0);
   endfunction

   // Largest gain shift that still keeps one sample bit inside the input word
   function automatic int max_shift(input int in_w);
      return in_w - 1;
   endfunction

endpackage

// File: rtl/dac_gain_scaler_ramp.sv
// gain_ramp: free-running divider that walks the applied gain shift one step
// per divider wrap toward the clamped requested shift.
module gain_ramp
   import dac_gain_scaler_pkg::*;
#(
   parameter int SHIFT_W   = 8,
   parameter int RAMP_DIV  = 64,
   parameter int MAX_SHIFT = 27
) (
   input  logic               clk_in,
   input  logic               rst_in,
   input  logic [SHIFT_W-1:0] distance_in,
   output logic [SHIFT_W-1:0] shift_cur_out
);

   localparam int                 DIV_W       = (RAMP_DIV > 1) ? $clog2(RAMP_DIV) : 1;
   localparam logic [DIV_W-1:0]   DIV_LAST    = DIV_W'(RAMP_DIV - 1);
   localparam logic [SHIFT_W-1:0] SHIFT_LIMIT = SHIFT_W'(MAX_SHIFT);

   logic [DIV_W-1:0]   div_cnt;
   logic               div_wrap;
   logic [SHIFT_W-1:0] target;
   logic [SHIFT_W-1:0] shift_cur;
   ramp_dir_e          dir;

   // Clamp the request and decide which way the next step goes; a new
   // request takes effect at the very next wrap without touching the divider
   always_comb begin
      target   = (distance_in > SHIFT_LIMIT) ? SHIFT_LIMIT : distance_in;
      div_wrap = (div_cnt == DIV_LAST);
      if (target > shift_cur) begin
         dir = RAMP_UP;
      end else if (target < shift_cur) begin
         dir = RAMP_DOWN;
      end else begin
         dir = RAMP_HOLD;
      end
   end

   // Divider runs continuously; the applied shift moves only on its wrap
   always_ff @(posedge clk_in or posedge rst_in) begin
      if (rst_in) begin
         div_cnt   <= '0;
         shift_cur <= '0;
      end else begin
         div_cnt <= div_wrap ? '0 : div_cnt + DIV_W'(1);
         if (div_wrap) begin
            case (dir)
               RAMP_UP:   shift_cur <= shift_cur + SHIFT_W'(1);
               RAMP_DOWN: shift_cur <= shift_cur - SHIFT_W'(1);
               default:   shift_cur <= shift_cur;
            endcase
         end
      end
   end

   assign shift_cur_out = shift_cur;

endmodule

// File: rtl/dac_gain_scaler.sv
// dac_gain_scaler: 3-stage path from a wide signed sample to a DAC code.
// Stage 0 captures the sample with the gain shift in force, stage 1 shifts
// and clamps to the input range, stage 2 rounds to the DAC width, clamps the
// rounding carry and formats the code. Clipped outputs are counted.
module dac_gain_scaler
   import dac_gain_scaler_pkg::*;
#(
   parameter int IN_W       = 28,
   parameter int OUT_W      = 14,
   parameter int SHIFT_W    = 8,
   parameter int RAMP_DIV   = 64,
   parameter int OFFSET_BIN = 1
) (
   input  logic                  clk_in,
   input  logic                  rst_in,
   input  logic [IN_W-1:0]       data_in,
   input  logic                  data_valid_in,
   input  logic [SHIFT_W-1:0]    distance_in,
   input  logic                  clip_count_clr_in,
   output logic [OUT_W-1:0]      data_out,
   output logic                  data_valid_out,
   output logic                  clip_out,
   output logic [CLIP_CNT_W-1:0] clip_count_out,
   output logic [SHIFT_W-1:0]    shift_cur_out
);

   localparam int WIDE_W = 2 * IN_W - 1;
   localparam int FRAC_W = IN_W - OUT_W;

   localparam logic signed [IN_W-1:0] IN_MAX     = IN_W'(signed_max(IN_W));
   localparam logic signed [IN_W-1:0] IN_MIN     = IN_W'(signed_min(IN_W));
   localparam logic [OUT_W-1:0]       OUT_MAX    = OUT_W'(signed_max(OUT_W));
   localparam logic [OUT_W-1:0]       MIDSCALE   = OUT_W'(midscale_code(OUT_W, OFFSET_BIN));
   localparam logic [IN_W:0]          ROUND_HALF = (IN_W + 1)'(longint'(1) << (FRAC_W - 1));
   localparam logic [CLIP_CNT_W-1:0]  CNT_MAX    = '1;

   // Shift at full width, then clamp into the signed IN_W range.
   // Result packs {clip, value}.
   function automatic logic [IN_W:0] shift_sat(input logic signed [IN_W-1:0] d,
                                               input logic [SHIFT_W-1:0]     sh);
      logic signed [WIDE_W-1:0] wide;
      wide = WIDE_W'(d) <<< sh;
      if (wide > WIDE_W'(IN_MAX)) begin
         return {1'b1, IN_MAX};
      end else if (wide < WIDE_W'(IN_MIN)) begin
         return {1'b1, IN_MIN};
      end
      return {1'b0, wide[IN_W-1:0]};
   endfunction

   // Round half up to OUT_W bits; only a positive value can carry out of
   // range, so that is the one case clamped. Result packs {clip, code}.
   function automatic logic [OUT_W:0] round_sat(input logic signed [IN_W-1:0] v);
      logic [IN_W:0] sum;
      sum = {v[IN_W-1], v} + ROUND_HALF;
      if (!sum[IN_W] && sum[IN_W-1]) begin
         return {1'b1, OUT_MAX};
      end
      return {1'b0, sum[IN_W-1:FRAC_W]};
   endfunction

   // Offset-binary is two's complement with the sign bit inverted
   function automatic logic [OUT_W-1:0] fmt_code(input logic [OUT_W-1:0] c);
      if (OFFSET_BIN != 0) begin
         return {~c[OUT_W-1], c[OUT_W-2:0]};
      end
      return c;
   endfunction

   logic [SHIFT_W-1:0]      shift_cur;

   logic                    vld_p0;
   logic signed [IN_W-1:0]  data_p0;
   logic [SHIFT_W-1:0]      shift_p0;

   logic                    vld_p1;
   logic signed [IN_W-1:0]  sat_p1;
   logic                    clip_p1;

   logic                    vld_p2;
   logic [OUT_W-1:0]        code_p2;
   logic                    clip_p2;

   logic [CLIP_CNT_W-1:0]   clip_cnt;

   logic [IN_W:0]           sat_res;
   logic [OUT_W:0]          rnd_res;
   logic                    clip_new;

   gain_ramp #(
      .SHIFT_W   (SHIFT_W),
      .RAMP_DIV  (RAMP_DIV),
      .MAX_SHIFT (max_shift(IN_W))
   ) u_gain_ramp (
      .clk_in        (clk_in),
      .rst_in        (rst_in),
      .distance_in   (distance_in),
      .shift_cur_out (shift_cur)
   );

   // Combinational work of stage 1 (shift/clamp) and stage 2 (round/clamp)
   always_comb begin
      sat_res  = shift_sat(data_p0, shift_p0);
      rnd_res  = round_sat(sat_p1);
      clip_new = clip_p1 | rnd_res[OUT_W];
   end

   // Valid chain; reset drops every sample in flight
   always_ff @(posedge clk_in or posedge rst_in) begin
      if (rst_in) begin
         vld_p0 <= 1'b0;
         vld_p1 <= 1'b0;
         vld_p2 <= 1'b0;
      end else begin
         vld_p0 <= data_valid_in;
         vld_p1 <= vld_p0;
         vld_p2 <= vld_p1;
      end
   end

   // Stage 0: sample and the shift in force travel together from here on
   always_ff @(posedge clk_in) begin
      if (data_valid_in) begin
         data_p0  <= data_in;
         shift_p0 <= shift_cur;
      end
   end

   // Stage 1: register the shifted and clamped sample with its clip flag
   always_ff @(posedge clk_in) begin
      if (vld_p0) begin
         sat_p1  <= sat_res[IN_W-1:0];
         clip_p1 <= sat_res[IN_W];
      end
   end

   // Stage 2: output code and clip flag, holding through bubbles; reset
   // parks the DAC at midscale
   always_ff @(posedge clk_in or posedge rst_in) begin
      if (rst_in) begin
         code_p2 <= MIDSCALE;
         clip_p2 <= 1'b0;
      end else if (vld_p1) begin
         code_p2 <= fmt_code(rnd_res[OUT_W-1:0]);
         clip_p2 <= clip_new;
      end
   end

   // Saturating clip counter; clear beats a same-cycle increment
   always_ff @(posedge clk_in or posedge rst_in) begin
      if (rst_in) begin
         clip_cnt <= '0;
      end else if (clip_count_clr_in) begin
         clip_cnt <= '0;
      end else if (vld_p1 && clip_new && (clip_cnt != CNT_MAX)) begin
         clip_cnt <= clip_cnt + CLIP_CNT_W'(1);
      end
   end

   assign data_out       = code_p2;
   assign data_valid_out = vld_p2;
   assign clip_out       = clip_p2;
   assign clip_count_out = clip_cnt;
   assign shift_cur_out  = shift_cur;

endmodule

// File: tb/tb_dac_gain_scaler.sv
// Bench for dac_gain_scaler: random and directed stimulus against an
// arithmetic reference model (integer shift, clamp, floor rounding, offset).
module tb_dac_gain_scaler;

   localparam int IN_W     = 28;
   localparam int OUT_W    = 14;
   localparam int SHIFT_W  = 8;
   localparam int RAMP_DIV = 64;

   logic               clk_in            = 1'b0;
   logic               rst_in            = 1'b0;
   logic [IN_W-1:0]    data_in           = '0;
   logic               data_valid_in     = 1'b0;
   logic [SHIFT_W-1:0] distance_in       = '0;
   logic               clip_count_clr_in = 1'b0;
   logic [OUT_W-1:0]   data_out;
   logic               data_valid_out;
   logic               clip_out;
   logic [15:0]        clip_count_out;
   logic [SHIFT_W-1:0] shift_cur_out;

   int n_checks = 0;
   int n_errors = 0;

   typedef struct {
      longint due;
      int     code;
      bit     clip;
   } exp_t;

   exp_t   exp_q[$];
   longint cyc     = 0;
   int     m_div   = 0;
   int     m_shift = 0;
   int     m_out   = 8192;
   int     m_cnt   = 0;
   bit     m_vld   = 1'b0;
   bit     m_clip  = 1'b0;

   dac_gain_scaler #(
      .IN_W       (IN_W),
      .OUT_W      (OUT_W),
      .SHIFT_W    (SHIFT_W),
      .RAMP_DIV   (RAMP_DIV),
      .OFFSET_BIN (1)
   ) dut (
      .clk_in            (clk_in),
      .rst_in            (rst_in),
      .data_in           (data_in),
      .data_valid_in     (data_valid_in),
      .distance_in       (distance_in),
      .clip_count_clr_in (clip_count_clr_in),
      .data_out          (data_out),
      .data_valid_out    (data_valid_out),
      .clip_out          (clip_out),
      .clip_count_out    (clip_count_out),
      .shift_cur_out     (shift_cur_out)
   );

   always #5 clk_in = ~clk_in;

   task automatic chk(input string tag, input longint got, input longint exp);
      n_checks++;
      if (got != exp) begin
         n_errors++;
         $display("FAIL %s: observed 0x%0h, expected 0x%0h", tag, got, exp);
      end
   endtask

   // Expected DAC code for one sample: value * 2^sh, clamp, floor((v+half)/2^14)
   function automatic void model_sample(input logic [IN_W-1:0] d, input int sh,
                                        output int code, output bit clip);
      logic signed [IN_W-1:0] ds;
      longint v, hi, lo, q, qmax;
      ds   = d;
      v    = ds;
      hi   = (longint'(1) << (IN_W - 1)) - 1;
      lo   = -(longint'(1) << (IN_W - 1));
      qmax = (longint'(1) << (OUT_W - 1)) - 1;
      v    = v * (longint'(1) << sh);
      clip = 1'b0;
      if (v > hi) begin
         v = hi; clip = 1'b1;
      end else if (v < lo) begin
         v = lo; clip = 1'b1;
      end
      q = (v + (longint'(1) << (IN_W - OUT_W - 1))) >>> (IN_W - OUT_W);
      if (q > qmax) begin
         q = qmax; clip = 1'b1;
      end
      code = int'(q + (longint'(1) << (OUT_W - 1)));
   endfunction

   // One clock: advance the model with the inputs seen at the edge, then compare
   task automatic step();
      int   c;
      bit   cl;
      int   tgt;
      exp_t e;
      @(posedge clk_in);
      cyc++;
      if (data_valid_in) begin
         model_sample(data_in, m_shift, c, cl);
         exp_q.push_back('{due: cyc + 2, code: c, clip: cl});
      end
      m_vld = 1'b0;
      if (exp_q.size() > 0 && exp_q[0].due == cyc) begin
         e      = exp_q.pop_front();
         m_vld  = 1'b1;
         m_out  = e.code;
         m_clip = e.clip;
      end
      if (clip_count_clr_in) m_cnt = 0;
      else if (m_vld && m_clip && m_cnt < 65535) m_cnt++;
      tgt = (int'(distance_in) > IN_W - 1) ? IN_W - 1 : int'(distance_in);
      if (m_div == RAMP_DIV - 1) begin
         m_div = 0;
         if (m_shift < tgt) m_shift++;
         else if (m_shift > tgt) m_shift--;
      end else begin
         m_div++;
      end
      #1;
      chk("valid", data_valid_out, m_vld);
      chk("data", data_out, m_out);
      chk("clip", clip_out, m_clip);
      chk("count", clip_count_out, m_cnt);
      chk("shift", shift_cur_out, m_shift);
   endtask

   task automatic apply_reset();
      rst_in = 1'b1;
      #1;
      exp_q.delete();
      m_div = 0; m_shift = 0; m_vld = 1'b0; m_out = 8192; m_clip = 1'b0; m_cnt = 0;
      chk("rst_data_midscale", data_out, 14'h2000);
      chk("rst_valid", data_valid_out, 0);
      chk("rst_clip", clip_out, 0);
      chk("rst_count", clip_count_out, 0);
      chk("rst_shift", shift_cur_out, 0);
      repeat (2) @(posedge clk_in);
      #1 rst_in = 1'b0;
   endtask

   // Single sample, then wait until it reaches the output
   task automatic send(input logic [IN_W-1:0] d);
      data_in       = d;
      data_valid_in = 1'b1;
      step();
      data_valid_in = 1'b0;
      step();
      step();
   endtask

   initial begin
      int     nsteps;
      int     prev;
      longint last;
      int     tmp;

      #2;
      apply_reset();

      // Latency and rounding at unity gain
      send(28'h0100000);
      chk("lat_valid", data_valid_out, 1);
      chk("lat_data", data_out, 14'h2040);
      chk("lat_clip", clip_out, 0);
      step();
      chk("strobe_one_cycle", data_valid_out, 0);
      chk("bubble_hold", data_out, 14'h2040);
      send(28'h0000001);
      chk("round_small", data_out, 14'h2000);

      // Randomized traffic, gain requests and clears
      for (int i = 0; i < 600; i++) begin
         tmp               = int'($urandom);
         data_in           = IN_W'(tmp >>> $urandom_range(4, 31));
         data_valid_in     = ($urandom_range(0, 3) != 0);
         clip_count_clr_in = ($urandom_range(0, 49) == 0);
         if (i % 100 == 0) distance_in = SHIFT_W'($urandom_range(0, 40));
         step();
      end
      data_valid_in     = 1'b0;
      clip_count_clr_in = 1'b0;
      repeat (3) step();

      // Reset with two samples in flight
      distance_in   = '0;
      data_in       = 28'h0100000;
      data_valid_in = 1'b1;
      step();
      data_in = 28'h0200000;
      step();
      data_valid_in = 1'b0;
      apply_reset();
      for (int i = 0; i < 6; i++) begin
         step();
         chk("post_rst_no_valid", data_valid_out, 0);
      end

      // Ramp 0 -> 4 in single steps at divider-wrap intervals
      distance_in = 8'd4;
      nsteps = 0;
      prev   = int'(shift_cur_out);
      last   = cyc;
      for (int i = 0; i < 300; i++) begin
         step();
         if (int'(shift_cur_out) != prev) begin
            nsteps++;
            chk("ramp_step_value", shift_cur_out, nsteps);
            if (nsteps > 1) chk("ramp_interval", cyc - last, RAMP_DIV);
            last = cyc;
            prev = int'(shift_cur_out);
         end
      end
      chk("ramp_reached", shift_cur_out, 4);
      send(28'h0100000);
      chk("ramp_gain_data", data_out, 14'h2400);

      // Saturation both ways at shift 2
      distance_in = 8'd2;
      repeat (3 * RAMP_DIV) step();
      chk("shift2", shift_cur_out, 2);
      clip_count_clr_in = 1'b1;
      step();
      clip_count_clr_in = 1'b0;
      chk("clr_count", clip_count_out, 0);
      data_in       = 28'h4000000;
      data_valid_in = 1'b1;
      step();
      data_in = 28'hC000000;
      step();
      data_valid_in = 1'b0;
      step();
      chk("sat_pos_data", data_out, 14'h3FFF);
      chk("sat_pos_clip", clip_out, 1);
      step();
      chk("sat_neg_data", data_out, 14'h0000);
      chk("sat_neg_clip", clip_out, 1);
      chk("sat_count", clip_count_out, 2);

      // Rounding carry overflow at unity gain, then shift clamp at 27
      distance_in = 8'd0;
      repeat (3 * RAMP_DIV) step();
      chk("shift0", shift_cur_out, 0);
      send(28'h7FFFFFF);
      chk("rnd_ovf_data", data_out, 14'h3FFF);
      chk("rnd_ovf_clip", clip_out, 1);
      distance_in = 8'd200;
      repeat (28 * RAMP_DIV) step();
      chk("shift_clamp", shift_cur_out, 27);
      repeat (2 * RAMP_DIV) step();
      chk("shift_clamp_hold", shift_cur_out, 27);

      // Counter saturation and clear-over-increment
      data_in       = 28'h4000000;
      data_valid_in = 1'b1;
      repeat (65540) step();
      chk("count_sat", clip_count_out, 16'hFFFF);
      repeat (4) step();
      chk("count_sat_hold", clip_count_out, 16'hFFFF);
      clip_count_clr_in = 1'b1;
      step();
      clip_count_clr_in = 1'b0;
      chk("clr_wins", clip_count_out, 0);
      step();
      chk("count_after_clr", clip_count_out, 1);
      data_valid_in = 1'b0;
      repeat (3) step();

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule

// File: doc/dac_gain_scaler.md
DAC_GAIN_SCALER -- requirements
Module: dac_gain_scaler

Interface
REQ-001 Parameters SHALL be (name, default, meaning):
  IN_W, 28, signed input sample width
  OUT_W, 14, DAC code width, OUT_W < IN_W
  SHIFT_W, 8, width of shift request
  RAMP_DIV, 64, clocks per one-step shift change, >= 1
  OFFSET_BIN, 1, 1 = offset-binary output, 0 = two's complement output
REQ-002 Ports SHALL be (name, direction, width, meaning):
  clk_in  in  1  single clock, all logic on its rising edge
  rst_in  in  1  reset, asynchronous, active-high
  data_in  in  IN_W  signed sample
  data_valid_in  in  1  data_in qualifier
  distance_in  in  SHIFT_W  unsigned requested left-shift (gain)
  clip_count_clr_in  in  1  synchronous clear of clip counter
  data_out  out  OUT_W  DAC code
  data_valid_out  out  1  one-cycle strobe per produced code
  clip_out  out  1  sample of current data_out was saturated
  clip_count_out  out  16  saturating count of clipped samples
  shift_cur_out  out  SHIFT_W  gain shift currently applied

Function
REQ-003 Pipeline SHALL be 3 stages: capture, shift/saturate, round/format; data_valid_out SHALL rise exactly 3 clocks after the data_valid_in cycle.
REQ-004 Bubbles: data_valid_in low SHALL propagate as data_valid_out low; data_out and clip_out SHALL hold their last values.
REQ-005 Effective target shift SHALL be min(distance_in, IN_W-1).
REQ-006 Ramp: a divider counter SHALL count 0..RAMP_DIV-1; on wrap, shift_cur_out SHALL move one step toward target (+1 or -1), unchanged if equal; ramp SHALL run independent of data_valid_in.
REQ-007 Stage 1 SHALL latch data_in together with shift_cur_out; a shift change never splits one sample.
REQ-008 Stage 2 SHALL compute data_in << shift at IN_W+IN_W-1 bits; if the result is outside the signed IN_W range it SHALL saturate to +(2^(IN_W-1)-1) or -2^(IN_W-1) and set a clip flag.
REQ-009 Stage 3 SHALL add 2^(IN_W-OUT_W-1) (round half up) and take bits [IN_W-1:IN_W-OUT_W]; positive overflow from rounding SHALL saturate to 2^(OUT_W-1)-1 and set the clip flag.
REQ-010 Format: OFFSET_BIN=1 SHALL invert the MSB of the signed code; OFFSET_BIN=0 SHALL pass it unchanged.
REQ-011 clip_out SHALL be updated with data_out on each valid output.
REQ-012 clip_count_out SHALL increment on each valid clipped output and saturate at 0xFFFF; clip_count_clr_in SHALL win over simultaneous increment (result 0).
REQ-013 distance_in changes mid-ramp SHALL retarget immediately; the ramp divider SHALL NOT restart.

Reset
REQ-014 rst_in high SHALL asynchronously clear all pipeline valids, ramp divider, shift_cur_out, clip_out and clip_count_out to 0.
REQ-015 During reset data_out SHALL be midscale: 2^(OUT_W-1) when OFFSET_BIN=1, 0 when OFFSET_BIN=0.
REQ-016 Reset mid-operation SHALL discard in-flight samples; no data_valid_out SHALL appear for samples captured before reset release.

Structure
REQ-017 Shared package SHALL hold the clip counter width (16) and the midscale/saturation constant functions of OUT_W and IN_W.
REQ-018 Ramp divider plus shift stepping SHALL be one sub-module, gain_ramp, outputting shift_cur_out.
REQ-019 Expected size: 150-300 lines of RTL; no memories, no multipliers.

Verification (defaults, OFFSET_BIN=1)
REQ-020 Latency/rounding: shift 0, data_in 0x0100000 valid one cycle -> 3 clocks later data_out 0x2040, clip_out 0; data_in 0x0000001 -> 0x2000.
REQ-021 Ramp: distance_in 0->4 at t0 -> shift_cur_out steps 1,2,3,4 at 64-clock intervals; data_in 0x0100000 then yields 0x2400.
REQ-022 Saturation: shift 2, data_in 0x4000000 -> 0x3FFF, clip_out 1; data_in 0xC000000 -> 0x0000, clip_out 1; clip_count_out 2.
REQ-023 Rounding overflow: shift 0, data_in 0x7FFFFFF -> 0x3FFF, clip_out 1; distance_in 200 -> shift_cur_out stops at 27.
REQ-024 Counter edges: preload 0xFFFF via clipped stream -> holds 0xFFFF; clip_count_clr_in with clipped output same cycle -> 0.
REQ-025 Reset: assert rst_in with 2 samples in flight -> data_out 0x2000 immediately, no data_valid_out after release until new input.
